// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: one-cold column drive, 2-flop row synchroniser, tick-based press/release debounce.
// Optional auto-repeat while a key is held is enabled by defining KEYPAD_REPEAT_EN.
module keypad_scanner #(
  parameter int CLK_DIV        = 49999,
  parameter int DEBOUNCE_TICKS = 20,
  parameter int REPEAT_DELAY   = 500,
  parameter int REPEAT_RATE    = 100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int MAX_AB = (CLK_DIV > DEBOUNCE_TICKS) ? CLK_DIV : DEBOUNCE_TICKS;
  localparam int MAX_CD = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int MAXP   = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CW     = $clog2(MAXP) + 1;

  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_TICKS);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
`ifdef KEYPAD_REPEAT_EN
  // Reloading to DELAY-RATE lets one terminal compare serve both the first and later repeats.
  localparam logic [CW-1:0] REP_LAST   = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] REP_RELOAD = CW'(REPEAT_DELAY - REPEAT_RATE);
`endif

  typedef enum logic [1:0] {SCAN, PRESS_DEB, HELD, REL_DEB} state_t;
  state_t state;

  logic [3:0]    row_s1, row_s2;
  logic [CW-1:0] div_cnt;
  logic [CW-1:0] deb_cnt;
  logic          tick;
  logic [1:0]    col_idx, col_nidx, cap_row, low_idx;
  logic          any_low, cap_high;
`ifdef KEYPAD_REPEAT_EN
  logic [CW-1:0] rep_cnt;
`endif

  function automatic logic [3:0] col_drive(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_s1 <= 4'hF;
      row_s2 <= 4'hF;
    end else begin
      row_s1 <= row;
      row_s2 <= row_s1;
    end
  end

  assign tick = (div_cnt == DIV_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) div_cnt <= '0;
    else        div_cnt <= tick ? '0 : div_cnt + CNT_ONE;
  end

  // Lowest-index low row wins when several keys share the driven column.
  always_comb begin
    low_idx = 2'd0;
    any_low = 1'b0;
    for (int r = 3; r >= 0; r--) begin
      if (!row_s2[r]) begin
        low_idx = 2'(r);
        any_low = 1'b1;
      end
    end
  end

  assign cap_high = row_s2[cap_row];
  assign col_nidx = col_idx + 2'd1;

  // key_valid is a one-clk strobe with no back-pressure; key_code is stable
  // while key_valid is high and holds until the next accepted press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SCAN;
      col_idx   <= 2'd0;
      col       <= 4'b1110;
      cap_row   <= 2'd0;
      deb_cnt   <= '0;
      key_code  <= 4'd0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt   <= '0;
`endif
    end else begin
      key_valid <= 1'b0;
      if (tick) begin
        unique case (state)
          SCAN: begin
            if (any_low) begin
              cap_row <= low_idx;
              deb_cnt <= CNT_ONE;
              state   <= PRESS_DEB;
            end else begin
              col_idx <= col_nidx;
              col     <= col_drive(col_nidx);
            end
          end
          PRESS_DEB: begin
            if (!cap_high) begin
              if (deb_cnt == DEB_LAST) begin
                key_code  <= {cap_row, col_idx};
                key_valid <= 1'b1;
                key_held  <= 1'b1;
                state     <= HELD;
`ifdef KEYPAD_REPEAT_EN
                rep_cnt   <= '0;
`endif
              end else begin
                deb_cnt <= deb_cnt + CNT_ONE;
              end
            end else begin
              state   <= SCAN;
              col_idx <= col_nidx;
              col     <= col_drive(col_nidx);
            end
          end
          HELD: begin
            if (cap_high) begin
              deb_cnt <= CNT_ONE;
              state   <= REL_DEB;
`ifdef KEYPAD_REPEAT_EN
              rep_cnt <= '0;
            end else if (rep_cnt == REP_LAST) begin
              key_valid <= 1'b1;
              rep_cnt   <= REP_RELOAD;
            end else begin
              rep_cnt <= rep_cnt + CNT_ONE;
`endif
            end
          end
          REL_DEB: begin
`ifdef KEYPAD_REPEAT_EN
            rep_cnt <= '0;
`endif
            if (cap_high) begin
              if (deb_cnt == DEB_LAST) begin
                key_held <= 1'b0;
                state    <= SCAN;
                col_idx  <= col_nidx;
                col      <= col_drive(col_nidx);
              end else begin
                deb_cnt <= deb_cnt + CNT_ONE;
              end
            end else begin
              state <= HELD;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a keypad model drives rows from the column outputs; a scoreboard
// queue holds the key codes each press must report.
`timescale 1ns/1ps
module tb_keypad_scanner;
  localparam int CLK_DIV   = 3;
  localparam int DEB       = 4;
  localparam int REP_DELAY = 6;
  localparam int REP_RATE  = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] row, col, key_code;
  logic       key_valid, key_held;

  logic [15:0] keys = '0;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [3:0] exp_q[$];
  int rep_times[$];
  logic prev_valid = 1'b0;
  logic prev_held = 1'b0;
  logic [3:0] last_code = 4'd0;

  keypad_scanner #(
    .CLK_DIV(CLK_DIV), .DEBOUNCE_TICKS(DEB),
    .REPEAT_DELAY(REP_DELAY), .REPEAT_RATE(REP_RATE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .row(row), .col(col),
    .key_code(key_code), .key_valid(key_valid), .key_held(key_held)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // Cycles since reset release; ticks land on posedges where cyc % 4 == 0.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, want finish before 2ms");
    $fatal(1, "watchdog");
  end

  // Key r*4+c pulls row r low while column c is driven.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
      prev_held  = 1'b0;
    end else begin
      if (key_valid) begin
        total++;
        if (prev_valid) begin
          bad++;
          $display("FAIL valid_width: got key_valid high 2+ clks, want 1 clk");
        end
        if (prev_held) begin
`ifdef KEYPAD_REPEAT_EN
          total++;
          rep_times.push_back(cyc);
          if (key_code !== last_code) begin
            bad++;
            $display("FAIL repeat_code: got %0d want %0d", key_code, last_code);
          end
`else
          total++;
          bad++;
          $display("FAIL extra_valid: got pulse code=%0d while held, want none", key_code);
`endif
        end else if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_valid: got code=%0d, want no pulse", key_code);
        end else begin
          logic [3:0] e;
          e = exp_q.pop_front();
          last_code = e;
          total++;
          if (key_code !== e) begin
            bad++;
            $display("FAIL key_code: got %0d want %0d", key_code, e);
          end
          total++;
          if (key_held !== 1'b1) begin
            bad++;
            $display("FAIL held_on_accept: got %b want 1", key_held);
          end
        end
      end
      prev_valid = key_valid;
      prev_held  = key_held;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_col(input logic [3:0] c, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (col === c && (cyc % 4) == 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_held(input logic v, input int max_clk, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_clk; i++) begin
      @(negedge clk);
      if (key_held === v) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [3:0] scan_tab [5] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
    rst_n = 1'b0;
    keys  = '0;
    repeat (3) @(negedge clk);
    total++; if (col !== 4'b1110) begin bad++; $display("FAIL reset_col: got %b want 1110", col); end
    total++; if (key_code !== 4'd0) begin bad++; $display("FAIL reset_code: got %0d want 0", key_code); end
    total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", key_valid); end
    total++; if (key_held !== 1'b0) begin bad++; $display("FAIL reset_held: got %b want 0", key_held); end
    rst_n = 1'b1;
    for (int s = 0; s < 5; s++) begin
      while (cyc < 2 + 4*s) @(negedge clk);
      total++;
      if (col !== scan_tab[s]) begin
        bad++;
        $display("FAIL scan_col[%0d]: got %b want %b", s, col, scan_tab[s]);
      end
    end
    total++; if (key_held !== 1'b0) begin bad++; $display("FAIL idle_held: got %b want 0", key_held); end
  endtask

  task automatic test_clean_press();
    bit ok;
    int t0, t1, frozen_bad;
    wait_col(4'b1110, ok);
    total++; if (!ok) begin bad++; $display("FAIL press_align: got timeout want col 1110"); end
    keys[9] = 1'b1;
    exp_q.push_back(4'd9);
    wait_col(4'b1101, ok);
    t0 = cyc;
    total++; if (!ok) begin bad++; $display("FAIL press_col1: got timeout want col 1101"); end
    wait_held(1'b1, 200, ok);
    total++;
    if (!ok || cyc - t0 != 20) begin
      bad++;
      $display("FAIL press_latency: got %0d clk (ok=%0d) want 20", cyc - t0, ok);
    end
    frozen_bad = 0;
    repeat (140) begin
      @(negedge clk);
      if (col !== 4'b1101 || key_held !== 1'b1) frozen_bad++;
    end
    total++; if (frozen_bad != 0) begin bad++; $display("FAIL hold_frozen: got %0d bad clks want 0", frozen_bad); end
    while ((cyc % 4) != 0) @(negedge clk);
    keys[9] = 1'b0;
    t1 = cyc;
    while (cyc < t1 + 19) @(negedge clk);
    total++; if (key_held !== 1'b1) begin bad++; $display("FAIL release_early: got held=%b want 1", key_held); end
    @(negedge clk);
    total++; if (key_held !== 1'b0) begin bad++; $display("FAIL release_done: got held=%b want 0", key_held); end
    total++; if (col !== 4'b1011) begin bad++; $display("FAIL release_advance: got %b want 1011", col); end
    total++; if (key_code !== 4'd9) begin bad++; $display("FAIL code_holds: got %0d want 9", key_code); end
  endtask

  task automatic test_bounce();
    bit ok;
    int a;
    wait_col(4'b1011, ok);
    a = cyc;
    total++; if (!ok) begin bad++; $display("FAIL bounce_align: got timeout want col 1011"); end
    exp_q.push_back(4'd2);
    keys[2] = 1'b1;
    repeat (4) @(negedge clk);
    keys[2] = 1'b0;
    repeat (4) @(negedge clk);
    keys[2] = 1'b1;
    wait_held(1'b1, 200, ok);
    total++;
    if (!ok || cyc - a != 40) begin
      bad++;
      $display("FAIL bounce_latency: got %0d clk (ok=%0d) want 40", cyc - a, ok);
    end
    keys[2] = 1'b0;
    wait_held(1'b0, 200, ok);
    total++; if (!ok) begin bad++; $display("FAIL bounce_release: got held=%b want 0", key_held); end
    // 2-tick glitch: detected and counted once, then lost before acceptance.
    wait_col(4'b1011, ok);
    total++; if (!ok) begin bad++; $display("FAIL glitch_align: got timeout want col 1011"); end
    keys[2] = 1'b1;
    repeat (8) @(negedge clk);
    keys[2] = 1'b0;
    repeat (80) @(negedge clk);
    total++; if (key_held !== 1'b0) begin bad++; $display("FAIL glitch_held: got %b want 0", key_held); end
  endtask

  task automatic test_release_bounce();
    bit ok;
    int r0, drop;
    wait_col(4'b1101, ok);
    total++; if (!ok) begin bad++; $display("FAIL relb_align: got timeout want col 1101"); end
    keys[6] = 1'b1;
    exp_q.push_back(4'd6);
    wait_held(1'b1, 200, ok);
    total++; if (!ok) begin bad++; $display("FAIL relb_accept: got held=%b want 1", key_held); end
    repeat (8) @(negedge clk);
    while ((cyc % 4) != 0) @(negedge clk);
    r0 = cyc;
    keys[6] = 1'b0;
    repeat (8) @(negedge clk);
    keys[6] = 1'b1;
    repeat (8) @(negedge clk);
    keys[6] = 1'b0;
    drop = 0;
    while (cyc < r0 + 35) begin
      @(negedge clk);
      if (key_held !== 1'b1) drop++;
    end
    total++; if (drop != 0) begin bad++; $display("FAIL relb_held: got %0d low clks want 0", drop); end
    @(negedge clk);
    total++; if (key_held !== 1'b0) begin bad++; $display("FAIL relb_final: got held=%b want 0", key_held); end
  endtask

  task automatic test_multi_key();
    bit ok;
    wait_col(4'b0111, ok);
    total++; if (!ok) begin bad++; $display("FAIL multi_align: got timeout want col 0111"); end
    keys[4]  = 1'b1;
    keys[12] = 1'b1;
    exp_q.push_back(4'd4);
    wait_held(1'b1, 200, ok);
    total++; if (!ok) begin bad++; $display("FAIL multi_accept: got held=%b want 1", key_held); end
    keys[2] = 1'b1;
    repeat (60) @(negedge clk);
    total++;
    if (key_held !== 1'b1 || col !== 4'b1110) begin
      bad++;
      $display("FAIL multi_locked: got held=%b col=%b want 1 1110", key_held, col);
    end
    exp_q.push_back(4'd2);
    keys[4]  = 1'b0;
    keys[12] = 1'b0;
    wait_held(1'b0, 200, ok);
    total++; if (!ok) begin bad++; $display("FAIL multi_release: got held=%b want 0", key_held); end
    wait_held(1'b1, 200, ok);
    total++; if (!ok || key_code !== 4'd2) begin bad++; $display("FAIL second_key: got code=%0d held=%b want 2 1", key_code, key_held); end
    keys[2] = 1'b0;
    wait_held(1'b0, 200, ok);
    total++; if (!ok) begin bad++; $display("FAIL second_release: got held=%b want 0", key_held); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int t0;
    wait_col(4'b1011, ok);
    total++; if (!ok) begin bad++; $display("FAIL rmid_align: got timeout want col 1011"); end
    keys[15] = 1'b1;
    wait_col(4'b0111, ok);
    t0 = cyc;
    total++; if (!ok) begin bad++; $display("FAIL rmid_col3: got timeout want col 0111"); end
    while (cyc < t0 + 9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++; if (col !== 4'b1110) begin bad++; $display("FAIL rmid_col: got %b want 1110", col); end
    total++; if (key_code !== 4'd0) begin bad++; $display("FAIL rmid_code: got %0d want 0", key_code); end
    total++; if (key_held !== 1'b0 || key_valid !== 1'b0) begin bad++; $display("FAIL rmid_flags: got held=%b valid=%b want 0 0", key_held, key_valid); end
    keys[15] = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (120) @(negedge clk);
    total++; if (key_held !== 1'b0) begin bad++; $display("FAIL rmid_after: got held=%b want 0", key_held); end
    keys[15] = 1'b1;
    exp_q.push_back(4'd15);
    wait_held(1'b1, 300, ok);
    total++; if (!ok) begin bad++; $display("FAIL rmid_repress: got held=%b want 1", key_held); end
    keys[15] = 1'b0;
    wait_held(1'b0, 200, ok);
    total++; if (!ok) begin bad++; $display("FAIL rmid_rerelease: got held=%b want 0", key_held); end
  endtask

`ifdef KEYPAD_REPEAT_EN
  task automatic test_repeat();
    bit ok;
    int a;
    int want[4];
    wait_col(4'b1011, ok);
    total++; if (!ok) begin bad++; $display("FAIL rep_align: got timeout want col 1011"); end
    rep_times.delete();
    keys[7] = 1'b1;
    exp_q.push_back(4'd7);
    wait_held(1'b1, 200, ok);
    a = cyc;
    total++; if (!ok) begin bad++; $display("FAIL rep_accept: got held=%b want 1", key_held); end
    want = '{a + 24, a + 36, a + 48, a + 60};
    repeat (64) @(negedge clk);
    keys[7] = 1'b0;
    wait_held(1'b0, 200, ok);
    total++; if (rep_times.size() != 4) begin bad++; $display("FAIL rep_count: got %0d want 4", rep_times.size()); end
    for (int i = 0; i < 4 && i < rep_times.size(); i++) begin
      total++;
      if (rep_times[i] != want[i]) begin
        bad++;
        $display("FAIL rep_time[%0d]: got +%0d want +%0d clk", i, rep_times[i] - a, want[i] - a);
      end
    end
  endtask
`endif

  // ---------------- sequence and final report ----------------
  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_release_bounce();
    test_multi_key();
    test_reset_mid();
`ifdef KEYPAD_REPEAT_EN
    test_repeat();
`endif
    repeat (8) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL leftover_expected: got %0d unreported keys want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
Scans a 4x4 matrix keypad on the board's input side and delivers debounced key codes to the counter and display logic. It is the input-side counterpart of the multiplexed 7-segment driver: it drives one-cold column selects from a divided scan tick and reads the returned row lines instead of driving segments. Output is a one-clock key_valid strobe with a 4-bit key code, plus a held level.

Parameters:
CLK_DIV, 49999, clk cycles per scan tick minus 1 (1 ms at 50 MHz)
DEBOUNCE_TICKS, 20, consecutive stable ticks required for press and for release
REPEAT_DELAY, 500, ticks held before the first auto-repeat (only with KEYPAD_REPEAT_EN)
REPEAT_RATE, 100, ticks between auto-repeats (only with KEYPAD_REPEAT_EN)

Ports:
clk  input  1  system clock, single clock domain
rst_n  input  1  asynchronous active-low reset
row  input  4  keypad rows, active-low, pulled up externally, asynchronous to clk
col  output  4  column drive, one-cold active-low; 4'b1111 means no column driven
key_code  output  4  row_index*4 + col_index of the last accepted key
key_valid  output  1  one-clk strobe when key_code is newly valid
key_held  output  1  high from acceptance of a press until release is debounced

Behaviour:
- Reset (async, rst_n low): col=4'b1110 (column 0), key_code=0, key_valid=0, key_held=0, state=SCAN, divider, debounce and repeat counters=0, synchroniser=4'b1111.
- row passes through a 2-flop synchroniser; all decisions use the synchronised value (2-clk latency).
- Tick: divider counts 0..CLK_DIV, then wraps to 0; tick is a 1-clk pulse at wrap. All FSM actions below happen only on tick cycles, except that key_valid is cleared on the cycle after it is set.
- Rows are sampled on a tick for the column driven since the previous tick, which gives a full tick of settle time.
- SCAN: on tick, if any synced row bit is 0, capture col_idx and the lowest-index low row, set deb_cnt=1, hold the column, and go to PRESS_DEB. Otherwise advance col_idx 0->1->2->3->0.
- PRESS_DEB: on tick, if the captured row is still 0, deb_cnt++; when deb_cnt reaches DEBOUNCE_TICKS, set key_code=row*4+col, pulse key_valid, set key_held=1, and go to HELD. If the captured row is 1, return to SCAN and advance the column. A different row going low is ignored.
- HELD: the column stays fixed. On tick, if the captured row is 1, set deb_cnt=1 and go to REL_DEB.
- REL_DEB: on tick, if the captured row is 1, deb_cnt++; at DEBOUNCE_TICKS clear key_held, go to SCAN, and advance the column. If the captured row is 0, return to HELD with no new key_valid.
- Only one key is reported at a time. Other keys pressed while a key is held are not reported; scanning resumes after release.
- Simultaneous presses in one column: the lowest row index wins. Presses in different columns: the first column scanned wins.
- key_code holds its value after release until the next acceptance.
- Reset asserted mid-operation: immediate return to the reset values, with no key_valid pulse.
- Counter widths: $clog2 of the largest parameter value plus 1. No counter wraps before reaching its terminal value.

Optional Feature:
KEYPAD_REPEAT_EN
- Defined: in HELD, a rep_cnt counts ticks.
  - At REPEAT_DELAY, pulse key_valid with the same key_code and reload the count.
  - Every REPEAT_RATE ticks after that, pulse key_valid again.
  - rep_cnt clears on entry to HELD and on REL_DEB.
- Undefined: rep_cnt and the REPEAT_* parameters are unused. Exactly one key_valid is produced per press.

Test Plan:
All scenarios use CLK_DIV=3 and DEBOUNCE_TICKS=4 (tick every 4 clk).
- Reset, no keys: col cycles 1110,1101,1011,0111,1110, one step every 4 clk; key_valid never pulses; key_held=0.
- Clean press row=2 on col 1 for 40 ticks: exactly one key_valid with key_code=9, 4 ticks after first detection; key_held=1 until 4 ticks after release; col frozen at 1101 throughout.
- Bounce: row toggles every tick for 3 ticks, then stays low: no pulse during the bounce; one pulse with the correct code after 4 stable ticks. A 2-tick glitch alone produces no pulse.
- Release bounce: the row returns high for 2 ticks, then low, then high for 4+ ticks: key_held stays 1 until the final stable release, and no second key_valid occurs.
- Rows 1 and 3 low on col 0 together: key_code=4. A key in col 2 pressed while the first key is held is not reported until the first key is released.
- Reset asserted in PRESS_DEB at tick 2: outputs go to reset values immediately, and no key_valid occurs afterwards unless the key is pressed again. With KEYPAD_REPEAT_EN, REPEAT_DELAY=6 and REPEAT_RATE=3, holding a key for 15 ticks gives pulses at acceptance, +6, +9, +12 and +15 ticks.
